// File: rtl/snake_pkg.sv
// Shared types and constants for the snake engine.
// Direction codes, colours, FSM states, reversal helper.
package snake_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [2:0] COL_BG   = 3'b000;
  localparam logic [2:0] COL_BODY = 3'b001;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MOVE,
    S_ERASE,
    S_DRAW,
    S_DEAD
  } state_t;

  // left/right and up/down differ only in bit 0
  function automatic logic [1:0] opposite(
    input logic [1:0] d
  );
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_engine_cell_sweeper.sv
// Walks one CELL x CELL square in raster order
// through the plot/plot_ready handshake.
module cell_sweeper #(
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int CELL = 4,
  parameter int X0   = 80,
  parameter int Y0   = 60
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [X_W-1:0] cx,
  input  logic [Y_W-1:0] cy,
  input  logic [2:0]     colour,
  input  logic           plot_ready,
  output logic           plot,
  output logic [X_W-1:0] plot_x,
  output logic [Y_W-1:0] plot_y,
  output logic [2:0]     plot_colour,
  output logic           done
);

  localparam int CW = $clog2(CELL);

  logic [CW-1:0]  dx;
  logic [CW-1:0]  dy;
  logic [X_W-1:0] ox;
  logic [Y_W-1:0] oy;
  logic           fire;
  logic           last;

  assign fire   = plot & plot_ready;
  assign last   = (&dx) & (&dy);
  assign done   = fire & last;
  assign plot_x = ox + X_W'(dx);
  assign plot_y = oy + Y_W'(dy);

  // a start on the last accepted pixel chains
  // straight into the next cell without a gap
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot        <= 1'b0;
      ox          <= X_W'(X0);
      oy          <= Y_W'(Y0);
      plot_colour <= 3'b000;
      dx          <= '0;
      dy          <= '0;
    end else if (start) begin
      plot        <= 1'b1;
      ox          <= cx;
      oy          <= cy;
      plot_colour <= colour;
      dx          <= '0;
      dy          <= '0;
    end else if (fire) begin
      if (last) begin
        plot <= 1'b0;
      end else begin
        dx <= dx + 1'b1;
        if (&dx) dy <= dy + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake body buffer, movement, collision and
// draw/erase sequencing towards the VGA adapter.
module snake_engine
  import snake_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int CELL     = 4,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 6,
  parameter int START_X  = 80,
  parameter int START_Y  = 60,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       step,
  input  logic                       dir_valid,
  input  logic [1:0]                 dir,
  input  logic                       food_valid,
  input  logic [X_W-1:0]             food_x,
  input  logic [Y_W-1:0]             food_y,
  input  logic                       plot_ready,
  output logic                       plot,
  output logic [X_W-1:0]             plot_x,
  output logic [Y_W-1:0]             plot_y,
  output logic [2:0]                 plot_colour,
  output logic                       ate,
  output logic                       dead,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       busy
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;

  state_t         state;
  logic [1:0]     heading;
  logic [1:0]     pending;
  logic [X_W-1:0] seg_x [MAX_LEN];
  logic [Y_W-1:0] seg_y [MAX_LEN];
  logic [PW-1:0]  hp;
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  init_i;
  logic           kick;
  logic [X_W-1:0] er_x;
  logic [Y_W-1:0] er_y;
  logic [X_W-1:0] nh_x;
  logic [Y_W-1:0] nh_y;

  logic signed [X_W:0] nx;
  logic signed [Y_W:0] ny;
  logic [X_W-1:0] nxl;
  logic [Y_W-1:0] nyl;
  logic [PW-1:0]  tail_idx;
  logic [PW-1:0]  init_idx;
  logic wall;
  logic food_hit;
  logic grow;
  logic self_hit;

  logic           sw_start;
  logic [X_W-1:0] sw_cx;
  logic [Y_W-1:0] sw_cy;
  logic [2:0]     sw_col;
  logic           sw_done;

  assign length   = len_q;
  assign busy     = (state != S_IDLE);
  assign nxl      = nx[X_W-1:0];
  assign nyl      = ny[Y_W-1:0];
  assign tail_idx = hp - PW'(len_q - LW'(1));
  assign init_idx = hp - PW'(init_i);

  always_comb begin
    nx = $signed({1'b0, seg_x[hp]});
    ny = $signed({1'b0, seg_y[hp]});
    unique case (heading)
      DIR_LEFT:  nx = nx - (X_W+1)'(CELL);
      DIR_RIGHT: nx = nx + (X_W+1)'(CELL);
      DIR_UP:    ny = ny - (Y_W+1)'(CELL);
      DIR_DOWN:  ny = ny + (Y_W+1)'(CELL);
    endcase
  end

  assign wall = nx[X_W] | ny[Y_W]
              | (int'(nx) > SCREEN_W - CELL)
              | (int'(ny) > SCREEN_H - CELL);
  assign food_hit = food_valid
                  & ~nx[X_W] & ~ny[Y_W]
                  & (nxl == food_x)
                  & (nyl == food_y);
  assign grow = food_hit & (len_q < LW'(MAX_LEN));

  // the tail cell vacates this step unless we grow
  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_q)
          && (i != int'(len_q) - 1 || grow)
          && seg_x[hp - PW'(i)] == nxl
          && seg_y[hp - PW'(i)] == nyl)
        self_hit = 1'b1;
    end
  end

  always_comb begin
    sw_start = 1'b0;
    sw_cx    = nh_x;
    sw_cy    = nh_y;
    sw_col   = COL_BODY;
    unique case (state)
      S_INIT: begin
        sw_start = kick | (sw_done & (init_i < len_q));
        sw_cx    = seg_x[init_idx];
        sw_cy    = seg_y[init_idx];
      end
      S_ERASE: begin
        sw_start = kick | sw_done;
        if (kick) begin
          sw_cx  = er_x;
          sw_cy  = er_y;
          sw_col = COL_BG;
        end
      end
      S_DRAW:  sw_start = kick;
      default: sw_start = 1'b0;
    endcase
  end

  cell_sweeper #(
    .X_W (X_W),
    .Y_W (Y_W),
    .CELL(CELL),
    .X0  (START_X),
    .Y0  (START_Y)
  ) u_sweep (
    .clk        (clk),
    .resetn     (resetn),
    .start      (sw_start),
    .cx         (sw_cx),
    .cy         (sw_cy),
    .colour     (sw_col),
    .plot_ready (plot_ready),
    .plot       (plot),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_colour(plot_colour),
    .done       (sw_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_INIT;
      heading <= DIR_RIGHT;
      pending <= DIR_RIGHT;
      hp      <= PW'(INIT_LEN - 1);
      len_q   <= LW'(INIT_LEN);
      init_i  <= '0;
      kick    <= 1'b1;
      ate     <= 1'b0;
      dead    <= 1'b0;
      er_x    <= X_W'(START_X);
      er_y    <= Y_W'(START_Y);
      nh_x    <= X_W'(START_X);
      nh_y    <= Y_W'(START_Y);
      for (int j = 0; j < MAX_LEN; j++) begin
        if (j < INIT_LEN) begin
          seg_x[j] <= X_W'(START_X - (INIT_LEN - 1 - j) * CELL);
          seg_y[j] <= Y_W'(START_Y);
        end else begin
          seg_x[j] <= '0;
          seg_y[j] <= '0;
        end
      end
    end else begin
      ate  <= 1'b0;
      kick <= 1'b0;
      if (dir_valid && state != S_DEAD
          && dir != opposite(heading))
        pending <= dir;
      unique case (state)
        S_INIT: begin
          if (sw_start) init_i <= init_i + 1'b1;
          else if (sw_done) state <= S_IDLE;
        end
        S_IDLE: begin
          if (step) begin
            heading <= pending;
            state   <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (wall || self_hit) begin
            dead  <= 1'b1;
            state <= S_DEAD;
          end else begin
            hp                   <= hp + PW'(1);
            seg_x[hp + PW'(1)]   <= nxl;
            seg_y[hp + PW'(1)]   <= nyl;
            nh_x                 <= nxl;
            nh_y                 <= nyl;
            er_x                 <= seg_x[tail_idx];
            er_y                 <= seg_y[tail_idx];
            ate                  <= food_hit;
            kick                 <= 1'b1;
            if (grow) begin
              len_q <= len_q + 1'b1;
              state <= S_DRAW;
            end else begin
              state <= S_ERASE;
            end
          end
        end
        S_ERASE: if (sw_done) state <= S_DRAW;
        S_DRAW:  if (sw_done) state <= S_IDLE;
        default: state <= S_DEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Randomised bench for snake_engine against a
// queue-based model of the snake and its pixel stream.
module tb_snake_engine;

  logic       clk = 0;
  logic       resetn = 0;
  logic       step = 0;
  logic       dir_valid = 0;
  logic [1:0] dir = 0;
  logic       food_valid = 0;
  logic [7:0] food_x = 0;
  logic [6:0] food_y = 0;
  logic       plot_ready = 1;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       ate;
  logic       dead;
  logic [4:0] length;
  logic       busy;

  snake_engine #(
    .X_W(8), .Y_W(7), .CELL(4), .MAX_LEN(16),
    .INIT_LEN(6), .START_X(80), .START_Y(60),
    .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk), .resetn(resetn), .step(step),
    .dir_valid(dir_valid), .dir(dir),
    .food_valid(food_valid), .food_x(food_x),
    .food_y(food_y), .plot_ready(plot_ready),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .ate(ate),
    .dead(dead), .length(length), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];
  int bx[$];
  int by[$];
  int m_dir, m_pend, m_ate;
  bit m_dead;
  int pr_mode = 0;
  int pix_cnt = 0;
  int ate_seen = 0;
  int busy_cyc = 0;
  int last_pix = 0;
  int pr_cnt = 0;
  bit hold_v = 0;
  int hold_val = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  function automatic int pk(input int x, input int y, input int c);
    return (x << 16) | (y << 8) | c;
  endfunction

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic push_cell(input int cx, input int cy, input int c);
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++)
        exp_q.push_back(pk(cx + xx, cy + yy, c));
  endtask

  task automatic m_reset();
    exp_q.delete();
    bx.delete();
    by.delete();
    for (int i = 0; i < 6; i++) begin
      bx.push_back(80 - 4 * i);
      by.push_back(60);
    end
    m_dir = 1;
    m_pend = 1;
    m_dead = 0;
    for (int i = 0; i < 6; i++) push_cell(bx[i], by[i], 1);
  endtask

  function automatic void next_head(input int d, output int nx, output int ny);
    nx = bx[0];
    ny = by[0];
    case (d)
      0: nx -= 4;
      1: nx += 4;
      2: ny -= 4;
      default: ny += 4;
    endcase
  endfunction

  task automatic m_step();
    int nx, ny, tx, ty, n;
    bit fh, grow, hit;
    if (m_dead) return;
    m_dir = m_pend;
    next_head(m_dir, nx, ny);
    n = bx.size();
    fh = food_valid && nx == int'(food_x) && ny == int'(food_y);
    grow = fh && n < 16;
    hit = nx < 0 || nx + 4 > 160 || ny < 0 || ny + 4 > 120;
    for (int k = 0; k < n; k++)
      if ((k != n - 1 || grow) && bx[k] == nx && by[k] == ny) hit = 1;
    if (hit) begin
      m_dead = 1;
      return;
    end
    if (fh) m_ate++;
    bx.push_front(nx);
    by.push_front(ny);
    if (!grow) begin
      tx = bx.pop_back();
      ty = by.pop_back();
      push_cell(tx, ty, 0);
    end
    push_cell(nx, ny, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      pr_cnt++;
      case (pr_mode)
        0: plot_ready = 1;
        1: plot_ready = 1'($urandom % 2);
        default: plot_ready = (pr_cnt % 3 == 0);
      endcase
    end
  end

  // per-cycle compare of the pixel stream
  initial begin
    int cur;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold_v = 0;
      end else begin
        cur = pk(int'(plot_x), int'(plot_y), int'(plot_colour));
        if (hold_v) chk("hold", cur | (int'(plot) << 24), hold_val);
        if (plot && plot_ready) begin
          pix_cnt++;
          last_pix = cur;
          if (exp_q.size() == 0) chk("extra_pixel", cur, -1);
          else chk("pixel", cur, exp_q.pop_front());
        end
        hold_v = plot && !plot_ready;
        hold_val = cur | (1 << 24);
        if (ate) ate_seen++;
        if (busy) busy_cyc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset(input bit pins);
    resetn = 0;
    #1;
    if (pins) begin
      chk("rst_plot", int'(plot), 0);
      chk("rst_xyc", pk(int'(plot_x), int'(plot_y), int'(plot_colour)),
          pk(80, 60, 0));
      chk("rst_ate", int'(ate), 0);
      chk("rst_dead", int'(dead), 0);
      chk("rst_len", int'(length), 6);
      chk("rst_busy", int'(busy), 1);
    end
    m_reset();
    pix_cnt = 0;
    tick();
    resetn = 1;
    tick();
    wait_idle(2000);
    chk("init_left", exp_q.size(), 0);
  endtask

  task automatic send_dir(input int d);
    dir = 2'(d);
    dir_valid = 1;
    if (!m_dead && d != opp(m_dir)) m_pend = d;
    tick();
    dir_valid = 0;
  endtask

  task automatic do_step(input bit inj);
    bit was_dead = m_dead;
    step = 1;
    busy_cyc = 0;
    m_step();
    tick();
    step = 0;
    if (inj) begin
      repeat ($urandom_range(1, 10)) tick();
      if (busy) begin
        step = 1;
        tick();
        step = 0;
      end
    end
    if (m_dead) begin
      repeat (3) tick();
      chk("dead", int'(dead), 1);
      if (was_dead) chk("dead_plot", int'(plot), 0);
    end else begin
      wait_idle(2000);
    end
    chk("left_pixels", exp_q.size(), 0);
    chk("length", int'(length), bx.size());
    chk("ate_count", ate_seen, m_ate);
  endtask

  initial begin
    int a0, nx, ny;
    m_ate = 0;
    m_reset();
    tick();
    do_reset(1);
    chk("init_pixels", pix_cnt, 96);
    chk("init_last", last_pix, pk(63, 63, 1));
    chk("init_busy", int'(busy), 0);
    chk("init_len", int'(length), 6);

    pix_cnt = 0;
    do_step(0);
    chk("move_busy", busy_cyc, 34);
    chk("move_pixels", pix_cnt, 32);
    chk("move_head_x", bx[0], 84);

    send_dir(0);
    tick();
    do_step(0);
    chk("rev_head", pk(bx[0], by[0], 0), pk(88, 60, 0));
    send_dir(2);
    tick();
    do_step(0);
    chk("up_head", pk(bx[0], by[0], 0), pk(88, 56, 0));

    do_reset(0);
    food_valid = 1;
    food_x = 84;
    food_y = 60;
    a0 = ate_seen;
    pix_cnt = 0;
    do_step(0);
    food_valid = 0;
    chk("grow_ate", ate_seen - a0, 1);
    chk("grow_len", int'(length), 7);
    chk("grow_pixels", pix_cnt, 16);
    chk("grow_busy", busy_cyc, 18);

    do_reset(0);
    repeat (19) do_step(0);
    chk("wall_head", bx[0], 156);
    pix_cnt = 0;
    do_step(0);
    chk("wall_dead", int'(dead), 1);
    do_step(0);
    chk("wall_pixels", pix_cnt, 0);

    do_reset(0);
    pr_mode = 2;
    pix_cnt = 0;
    do_step(0);
    chk("slow_pixels", pix_cnt, 32);

    for (int it = 0; it < 120; it++) begin
      if (m_dead) do_reset(0);
      pr_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        send_dir($urandom_range(0, 3));
        tick();
      end
      food_valid = ($urandom % 3) != 0;
      if ($urandom % 2 == 0) begin
        next_head(m_pend, nx, ny);
        food_x = 8'(nx);
        food_y = 7'(ny);
      end else begin
        food_x = 8'(4 * $urandom_range(0, 39));
        food_y = 7'(4 * $urandom_range(0, 29));
      end
      if (it % 29 == 28) begin
        step = 1;
        m_step();
        tick();
        step = 0;
        repeat ($urandom_range(3, 12)) tick();
        resetn = 0;
        #1;
        chk("abort_plot", int'(plot), 0);
        m_reset();
        tick();
        resetn = 1;
        tick();
        wait_idle(2000);
        chk("abort_init", exp_q.size(), 0);
      end else begin
        do_step(($urandom % 4) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
